// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks an N-input combinational block through every
// input vector, waits DWELL settle cycles on each, samples the single-bit
// response into a truth-table register and keeps a running count of ones.
module truth_table_sweeper #(
    parameter int N     = 4,
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_f,
    output logic [N-1:0]      dut_a,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out,
    output logic [N:0]        ones_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last vector of the sweep and the settle-counter reload value.
    localparam logic [N-1:0] LAST_IDX   = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [7:0]   DWELL_LOAD = 8'(DWELL - 1);

    state_t          state_r;
    logic [N-1:0]    idx_r;
    logic [7:0]      cnt_r;

    // Sweep sequencer: state, vector index, settle counter and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= {N{1'b0}};
            cnt_r      <= 8'd0;
            dut_a      <= {N{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= {(2**N){1'b0}};
            ones_count <= {(N+1){1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    // abort outranks start: neither launches a sweep
                    if (start && !abort) begin
                        state_r    <= SETTLE;
                        idx_r      <= {N{1'b0}};
                        dut_a      <= {N{1'b0}};
                        table_out  <= {(2**N){1'b0}};
                        ones_count <= {(N+1){1'b0}};
                        cnt_r      <= DWELL_LOAD;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_r <= IDLE;
                        dut_a   <= {N{1'b0}};
                        busy    <= 1'b0;
                    end else if (cnt_r == 8'd0) begin
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                SAMPLE: begin
                    // an abort here also drops this cycle's capture
                    if (abort) begin
                        state_r <= IDLE;
                        dut_a   <= {N{1'b0}};
                        busy    <= 1'b0;
                    end else begin
                        table_out[idx_r] <= dut_f;
                        ones_count       <= ones_count + {{N{1'b0}}, dut_f};
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= SETTLE;
                            idx_r   <= idx_r + IDX_ONE;
                            dut_a   <= idx_r + IDX_ONE;
                            cnt_r   <= DWELL_LOAD;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    dut_a   <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed, table-driven check of the truth-table
// sweeper with a small behavioural DUT model, plus hand-written sequences
// for abort, mid-sweep reset and a second (N=3, DWELL=1) instance.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic        dut_f;
    logic [3:0]  dut_a;
    logic        busy, done;
    logic [15:0] table_out;
    logic [4:0]  ones_count;

    logic        start2;
    logic        dut_f2;
    logic [2:0]  dut_a2;
    logic        busy2, done2;
    logic [7:0]  table_out2;
    logic [3:0]  ones_count2;

    int model_mode;
    int n_vec = 0;
    int n_bad = 0;

    truth_table_sweeper #(.N(4), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_f(dut_f),
        .dut_a(dut_a), .busy(busy), .done(done),
        .table_out(table_out), .ones_count(ones_count)
    );

    truth_table_sweeper #(.N(3), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .dut_f(dut_f2),
        .dut_a(dut_a2), .busy(busy2), .done(done2),
        .table_out(table_out2), .ones_count(ones_count2)
    );

    always #5 clk = ~clk;

    // Behavioural models of the combinational blocks under sweep.
    always_comb begin
        case (model_mode)
            0: dut_f = ^dut_a;
            1: dut_f = &dut_a;
            2: dut_f = |dut_a;
            3: dut_f = 1'b0;
            4: dut_f = 1'b1;
            5: dut_f = dut_a[0];
            default: dut_f = 1'b0;
        endcase
    end
    assign dut_f2 = dut_a2[0];

    typedef struct {
        int          mode;
        logic [15:0] tab;
        logic [4:0]  ones;
        int          restart_at;
        bit          start_in_done;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full sweep of the N=4 instance, checking timing and results.
    task automatic sweep(input int mode, input int restart_at, input bit start_in_done,
                         input logic [15:0] exp_tab, input logic [4:0] exp_ones);
        int c;
        bit seq_ok, busy_ok;
        model_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        seq_ok = 1'b1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && c < 200) begin
            if (dut_a !== 4'(c / 3)) seq_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (c == restart_at);
            tick();
            c++;
        end
        start = 1'b0;
        chk("done_latency", c, 48);
        chk("vector_sequence", {31'd0, seq_ok}, 32'd1);
        chk("busy_during_sweep", {31'd0, busy_ok}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("dut_a_at_done", {28'd0, dut_a}, 32'd15);
        chk("table_out", {16'd0, table_out}, {16'd0, exp_tab});
        chk("ones_count", {27'd0, ones_count}, {27'd0, exp_ones});
        start = start_in_done;
        tick();
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        tick();
        chk("idle_holds", {31'd0, busy}, 32'd0);
        chk("table_held_idle", {16'd0, table_out}, {16'd0, exp_tab});
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; model_mode = 0;

        vecs[0] = '{0, 16'h6996, 5'd8,  -1, 1'b0};
        vecs[1] = '{1, 16'h8000, 5'd1,  -1, 1'b0};
        vecs[2] = '{0, 16'h6996, 5'd8,  10, 1'b0};
        vecs[3] = '{2, 16'hFFFE, 5'd15, -1, 1'b1};
        vecs[4] = '{3, 16'h0000, 5'd0,  -1, 1'b0};
        vecs[5] = '{4, 16'hFFFF, 5'd16, -1, 1'b0};
        vecs[6] = '{5, 16'hAAAA, 5'd8,  -1, 1'b0};

        tick(); tick();
        chk("rst_dut_a", {28'd0, dut_a}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_table", {16'd0, table_out}, 32'd0);
        chk("rst_ones", {27'd0, ones_count}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            sweep(vecs[i].mode, vecs[i].restart_at, vecs[i].start_in_done,
                  vecs[i].tab, vecs[i].ones);
        end

        // abort while vector 5 is applied to the parity model
        model_mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        c = 0;
        while (dut_a !== 4'd5 && c < 100) begin tick(); c++; end
        chk("reach_vec5", {31'd0, (c < 100)}, 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_dut_a", {28'd0, dut_a}, 32'd0);
        chk("abort_table", {16'd0, table_out}, 32'h0016);
        chk("abort_ones", {27'd0, ones_count}, 32'd3);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (done === 1'b1) saw_done = 1'b1;
                tick();
            end
            chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        end

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_over_start", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_over_start_hold", {31'd0, busy}, 32'd0);

        // synchronous reset in the middle of a sweep
        start = 1'b1; tick(); start = 1'b0;
        c = 0;
        while (dut_a !== 4'd9 && c < 100) begin tick(); c++; end
        chk("reach_vec9", {31'd0, (c < 100)}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_dut_a", {28'd0, dut_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_table", {16'd0, table_out}, 32'd0);
        chk("midrst_ones", {27'd0, ones_count}, 32'd0);
        tick();
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        sweep(0, -1, 1'b0, 16'h6996, 5'd8);

        // N=3, DWELL=1 instance sweeping f = a[0]
        begin
            bit seq_ok;
            seq_ok = 1'b1;
            start2 = 1'b1; tick(); start2 = 1'b0;
            c = 0;
            while (done2 !== 1'b1 && c < 100) begin
                if (dut_a2 !== 3'(c / 2)) seq_ok = 1'b0;
                tick();
                c++;
            end
            chk("i2_done_latency", c, 16);
            chk("i2_vector_sequence", {31'd0, seq_ok}, 32'd1);
            chk("i2_table", {24'd0, table_out2}, 32'h00AA);
            chk("i2_ones", {28'd0, ones_count2}, 32'd4);
            tick();
            chk("i2_done_one_cycle", {31'd0, done2}, 32'd0);
            chk("i2_busy_after", {31'd0, busy2}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that drives an N-input single-output combinational block (e.g. the 4-input adder/logic function) through all 2^N input vectors and captures the response into a truth-table register. It waits a programmable settle time on each vector, samples the output, and counts ones. It sits between a start/done control interface and the DUT, replacing hand-written exhaustive stimulus with a reusable hardware sweep.

Parameters:
N, 4, DUT input width; sweep covers vectors 0 .. 2^N-1.
DWELL, 2, settle cycles per vector before sampling; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a sweep when idle.
abort  input  1  stops an in-progress sweep.
dut_f  input  1  DUT output under test.
dut_a  output  N  vector driven to the DUT.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse on sweep completion.
table_out  output  2^N  captured truth table; bit i = dut_f observed for dut_a = i.
ones_count  output  N+1  number of 1s in table_out.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, dut_a=0, busy=0, done=0, table_out=0, ones_count=0, idx=0, dwell counter=0. Reset overrides every other input, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. If start=1: idx<=0, dut_a<=0, table_out<=0, ones_count<=0, cnt<=DWELL-1, go to SETTLE. table_out and ones_count hold their last values while idle.
- SETTLE: busy=1, dut_a stable. If cnt==0, go to SAMPLE; otherwise cnt<=cnt-1. Duration is exactly DWELL cycles.
- SAMPLE (one cycle): table_out[idx]<=dut_f and ones_count<=ones_count+dut_f. If idx==2^N-1, go to DONE. Otherwise idx<=idx+1, dut_a<=idx+1, cnt<=DWELL-1, go to SETTLE.
- DONE (one cycle): done=1, busy=0, dut_a holds the last vector. Next state is IDLE. start is ignored in this cycle.
- Per-vector cost is DWELL+1 cycles. done is high exactly 2^N*(DWELL+1) cycles after the edge that sampled start (N=4, DWELL=2: 48 cycles).
- start while busy (SETTLE or SAMPLE) is ignored; the sweep continues undisturbed.
- abort=1 in SETTLE or SAMPLE: go to IDLE next edge, dut_a<=0, no done pulse. Partially captured table_out and ones_count are retained. Any SAMPLE write in that same cycle is suppressed. abort has priority over start in IDLE (neither starts a sweep).
- Arithmetic: idx is N bits and never wraps during a sweep; ones_count is N+1 bits, so its maximum 2^N fits with no overflow.
- done and busy are registered outputs; there are no combinational paths from inputs to outputs.

Test Plan:
- DUT model f = XOR of a[3:0], pulse start -> dut_a steps 0..15, each vector held 3 cycles; done at cycle 48; table_out=16'h6996, ones_count=8.
- DUT model f = AND of a[3:0] -> table_out=16'h8000, ones_count=1; busy high for cycles 1..47, done for one cycle only.
- Pulse start again at cycle 10 of a sweep -> no restart; done still at cycle 48; result identical to single run.
- abort asserted while dut_a=5 (parity DUT) -> IDLE next cycle, dut_a=0, no done, table_out=16'h0016, ones_count=3.
- rst asserted mid-sweep (dut_a=9) -> next edge all outputs 0, state IDLE; a fresh start completes normally with the correct table.
- Instance with DWELL=1, N=3, f = a[0] -> done after 16 cycles, table_out=8'hAA, ones_count=4.
